// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the synchronous byte FIFO and its UART drain.
// master: the consumer (UART TX controller); slave: the FIFO itself.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Autonomous FIFO drain: pops one byte whenever the FIFO is non-empty and
// shifts it out as 8N1 (start, 8 data LSB first, stop). All outputs are flops.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic           clk,
  input  logic           rst,      // async, active low
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           tx_done
);

  // Guard the width math against an illegal CLKS_PER_BIT so the error below
  // is the message that reaches the user.
  localparam int BW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_WIDTH != 8) begin : g_bad_dw
      $error("fifo_uart_tx: only DATA_WIDTH == 8 is supported");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          rd_en_q;
  logic          busy_q;
  logic          done_q;
  logic          baud_end;

  // Last cycle of the current bit period.
  assign baud_end = (baud_q == BAUD_LAST);

  // Controller FSM; every output is registered here so the line never glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // Only state that looks at fifo_empty; a request is one pulse.
        IDLE: begin
          tx_q <= 1'b1;
          if (!fifo.fifo_empty) begin
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= REQ;
          end
        end
        // FIFO pops at the edge closing this cycle.
        REQ: begin
          rd_en_q <= 1'b0;
          state_q <= WAIT;
        end
        // FIFO output now holds the popped byte; capture it and drop the line.
        WAIT: begin
          shift_q <= fifo.fifo_data[7:0];
          tx_q    <= 1'b0;
          baud_q  <= '0;
          state_q <= START;
        end
        START: begin
          if (baud_end) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            bit_q   <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        // Shift right each bit period; tx always presents shift_q[0].
        DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_q  <= '0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx              = tx_q;
  assign busy            = busy_q;
  assign tx_done         = done_q;
  assign fifo.fifo_rd_en = rd_en_q;

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the 8-bit synchronous FIFO.
- Pops one byte at a time whenever the FIFO is non-empty and serialises it onto a UART line as 8N1: start bit, 8 data bits LSB first, 1 stop bit.
- Sits between the FIFO read port and the board TX pin, and drains the FIFO autonomously.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit period; legal range is 2 or more, elaboration error otherwise.
- DATA_WIDTH, 8, byte width; must match the FIFO data width, and only 8 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  8  FIFO data_out; valid the cycle after the FIFO samples rd_en.
- fifo_rd_en  output  1  FIFO read strobe; registered; single-cycle pulse per byte.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high in every state except IDLE.
- tx_done  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: tx=1, fifo_rd_en=0, busy=0, tx_done=0.
  - Internal: state=IDLE, bit counter=0, baud counter=0, shift register=0.
  - Reset mid-frame forces tx high immediately and discards the byte in flight. The FIFO entry already popped is lost; this is accepted.
- States: IDLE, REQ, WAIT, START, DATA, STOP.
- IDLE:
  - fifo_empty is sampled only in this state.
  - If fifo_empty=0 at an edge: fifo_rd_en<=1, state<=REQ. Otherwise remain in IDLE with tx=1.
- REQ (1 cycle): fifo_rd_en is high during this cycle, and the FIFO pops at the closing edge. At that edge: fifo_rd_en<=0, state<=WAIT.
- WAIT (1 cycle): fifo_data now holds the popped byte. At the closing edge: shift_reg<=fifo_data, tx<=0, baud counter<=0, state<=START.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then tx<=shift_reg[0], bit counter<=0, state<=DATA.
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles.
  - At the end of each bit period: shift right, and increment the bit counter.
  - After bit 7: tx<=1, state<=STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the final edge: tx_done<=1 for one cycle, state<=IDLE.
- Frame timing:
  - Frame length from the tx falling edge to the end of the stop bit is exactly 10*CLKS_PER_BIT cycles.
  - Latency from fifo_empty falling (sampled in IDLE) to the tx falling edge is 3 cycles.
- Back-to-back bytes: minimum inter-frame idle-high gap is 3 cycles (IDLE, REQ, WAIT). No other gaps.
- fifo_rd_en rules:
  - Never asserted when fifo_empty=1 was sampled.
  - Never asserted outside the IDLE->REQ transition.
  - Exactly one pulse per frame.
- Input stability: fifo_empty and fifo_data changes during a frame are ignored. fifo_data is sampled only at the WAIT exit edge.
- Counter widths:
  - Baud counter width is $clog2(CLKS_PER_BIT); it wraps to 0 at CLKS_PER_BIT-1.
  - Bit counter is 3 bits.
- Bit ordering: LSB first. tx is registered, so there are no combinational glitches.

Test Plan:
1. CLKS_PER_BIT=4, write 0xAA into the FIFO, release reset.
   - Exactly one fifo_rd_en pulse.
   - tx sequence, each bit 4 cycles: 0 | 0,1,0,1,0,1,0,1 | 1.
   - tx_done pulses once 40 cycles after the tx fall.
   - busy is high from REQ through STOP.
2. FIFO left empty for 200 cycles after reset: tx=1, fifo_rd_en=0, busy=0 throughout.
3. Write 0xAA, 0xBB, 0xCC, 0xDD, then stop writing.
   - Four frames decoded in order AA, BB, CC, DD.
   - Four rd_en pulses total.
   - 3-cycle high gap between frames.
   - FIFO empty after the 4th REQ; controller then stays in IDLE.
4. Fill the FIFO to full (8 bytes 0x01..0x08): all 8 are transmitted in order, and the FIFO full flag deasserts after the first pop.
5. Assert rst low mid-DATA of byte 0x55: tx goes high the same cycle (asynchronously), and busy and tx_done drop to 0. After release, transmission resumes with the next FIFO byte.
6. Write 0x00 and 0xFF with CLKS_PER_BIT=2:
   - Each frame is 20 cycles.
   - 0x00 holds tx low for 18 cycles.
   - 0xFF shows only the 2-cycle start bit low.
